// File: rtl/des_key_scheduler_if.sv
// Handshake and data bundle between a DES round datapath and its key scheduler.
// The master side drives start/key/advance; the scheduler (slave) returns subkeys and status.
interface des_key_scheduler_if;
  logic        start_strobe_din;
  logic        decrypt_mode_din;
  logic [0:63] key_din;
  logic        key_advance_din;
  logic [0:47] round_key_dout;
  logic        round_key_valid_dout;
  logic [3:0]  round_number_dout;
  logic        busy_dout;
  logic        done_strobe_dout;

  modport master (
    output start_strobe_din,
    output decrypt_mode_din,
    output key_din,
    output key_advance_din,
    input  round_key_dout,
    input  round_key_valid_dout,
    input  round_number_dout,
    input  busy_dout,
    input  done_strobe_dout
  );

  modport slave (
    input  start_strobe_din,
    input  decrypt_mode_din,
    input  key_din,
    input  key_advance_din,
    output round_key_dout,
    output round_key_valid_dout,
    output round_number_dout,
    output busy_dout,
    output done_strobe_dout
  );
endinterface

// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: one 48-bit subkey per advance, K1..K16 for encrypt
// and K16..K1 for decrypt, computed by rotating the PC-1 halves in place.
module des_key_scheduler (
  input  logic                 clk,
  input  logic                 reset,
  des_key_scheduler_if.slave   ks
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ROUND = 1'b1;

  // Tables hold 1-based FIPS bit positions.
  localparam int PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [0:55] pc1(input logic [0:63] key);
    logic [0:55] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[i] = key[PC1_TAB[i] - 1];
    end
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[i] = cd[PC2_TAB[i] - 1];
    end
    return r;
  endfunction

  // Left-shift count applied on the way into FIPS round `round` (1..16).
  function automatic logic [1:0] shift_of(input logic [4:0] round);
    logic [1:0] r;
    r = 2'd2;
    if (round == 5'd1 || round == 5'd2 || round == 5'd9 || round == 5'd16) begin
      r = 2'd1;
    end
    return r;
  endfunction

  function automatic logic [0:27] rotl(input logic [0:27] h, input logic [1:0] n);
    logic [0:27] r;
    r = {h[1:27], h[0]};
    if (n == 2'd2) begin
      r = {h[2:27], h[0:1]};
    end
    return r;
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] h, input logic [1:0] n);
    logic [0:27] r;
    r = {h[27], h[0:26]};
    if (n == 2'd2) begin
      r = {h[26:27], h[0:25]};
    end
    return r;
  endfunction

  logic [0:0]  state_q, state_d;
  logic [0:27] c_q, c_d;
  logic [0:27] d_q, d_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;

  logic [0:55] key_pc1;
  logic [1:0]  sh_enc;
  logic [1:0]  sh_dec;
  logic [4:0]  num_full;

  assign key_pc1 = pc1(ks.key_din);
  assign sh_enc  = shift_of(cnt_q + 5'd1);
  // Decrypt undoes the shift that led into the round currently being presented.
  assign sh_dec  = shift_of(5'd17 - cnt_q);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ks.start_strobe_din) begin
          state_d = ST_ROUND;
          cnt_d   = 5'd1;
          dec_d   = ks.decrypt_mode_din;
          // Shifts sum to 28, so the unrotated halves already give K16.
          if (ks.decrypt_mode_din) begin
            c_d = key_pc1[0:27];
            d_d = key_pc1[28:55];
          end else begin
            c_d = rotl(key_pc1[0:27], 2'd1);
            d_d = rotl(key_pc1[28:55], 2'd1);
          end
        end
      end
      default: begin
        if (ks.key_advance_din) begin
          if (cnt_q == 5'd16) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
            dec_d   = 1'b0;
            c_d     = '0;
            d_d     = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
            if (dec_q) begin
              c_d = rotr(c_q, sh_dec);
              d_d = rotr(d_q, sh_dec);
            end else begin
              c_d = rotl(c_q, sh_enc);
              d_d = rotl(d_q, sh_enc);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= 5'd0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  // Index 16 reads as 0 in four bits; round_key_valid_dout separates it from idle.
  always_comb begin
    num_full = 5'd0;
    if (state_q == ST_ROUND) begin
      num_full = dec_q ? (5'd17 - cnt_q) : cnt_q;
    end
  end

  assign ks.round_key_dout       = pc2({c_q, d_q});
  assign ks.round_key_valid_dout = (state_q == ST_ROUND);
  assign ks.busy_dout            = (state_q == ST_ROUND);
  assign ks.round_number_dout    = num_full[3:0];
  assign ks.done_strobe_dout     = done_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Bench for des_key_scheduler: golden FIPS subkeys for key 133457799BBCDFF1,
// table-driven schedules plus hand-written reset-abort and restart sequences.
module tb_des_key_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  des_key_scheduler_if ks();

  des_key_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .ks    (ks)
  );

  localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h133457799BBCDFF1 ^ 64'h0101010101010101;

  // K1..K16 of the classic worked example for KEY.
  localparam logic [47:0] GOLDEN [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct {
    logic [47:0] key;
    logic [3:0]  num;
    logic        valid;
    logic        busy;
    logic        done;
  } exp_t;

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic        stall;
    logic        restart5;
    logic [47:0] first_key;
    logic [3:0]  first_num;
    logic [47:0] last_key;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Index 16 wraps to 0 in the four-bit round number.
  function automatic exp_t exp_round(input int idx);
    exp_t e;
    e.key   = GOLDEN[idx-1];
    e.num   = 4'(idx);
    e.valid = 1'b1;
    e.busy  = 1'b1;
    e.done  = 1'b0;
    return e;
  endfunction

  function automatic exp_t exp_idle(input logic done);
    exp_t e;
    e.key   = '0;
    e.num   = 4'd0;
    e.valid = 1'b0;
    e.busy  = 1'b0;
    e.done  = done;
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, " sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, " key"},   {16'h0, ks.round_key_dout}, {16'h0, e.key});
    chk({tag, " num"},   {60'h0, ks.round_number_dout}, {60'h0, e.num});
    chk({tag, " valid"}, {63'h0, ks.round_key_valid_dout}, {63'h0, e.valid});
    chk({tag, " busy"},  {63'h0, ks.busy_dout}, {63'h0, e.busy});
    chk({tag, " done"},  {63'h0, ks.done_strobe_dout}, {63'h0, e.done});
  endtask

  task automatic step(input logic start, input logic [63:0] key, input logic dec,
                      input logic adv, input exp_t e, input string tag);
    ks.start_strobe_din = start;
    ks.key_din          = key;
    ks.decrypt_mode_din = dec;
    ks.key_advance_din  = adv;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  // Starts a schedule and walks it to the done pulse; ends in the done cycle.
  task automatic run_schedule(input vec_t v, input string tag);
    exp_t        e;
    int          idx;
    logic        adv;
    logic        st;
    logic [63:0] k;
    logic        d;
    logic [47:0] last_seen;
    e     = exp_round(v.dec ? 16 : 1);
    e.key = v.first_key;
    e.num = v.first_num;
    step(1'b1, v.key, v.dec, 1'b0, e, {tag, " start"});
    last_seen = '0;
    for (int s = 1; s <= 16; s++) begin
      idx = v.dec ? 17 - s : s;
      for (int c = 0; c < 8; c++) begin
        adv = 1'b1;
        if (v.stall && c < 4 && $urandom_range(0, 1) == 0) adv = 1'b0;
        st = 1'b0;
        k  = v.key;
        d  = v.dec;
        if (v.restart5 && s == 5 && c == 0) begin
          st = 1'b1;
          k  = v.key ^ 64'hFFFF0000FFFF0000;
          d  = ~v.dec;
        end
        if (s == 16) last_seen = ks.round_key_dout;
        if (!adv)          e = exp_round(idx);
        else if (s < 16)   e = exp_round(v.dec ? idx - 1 : idx + 1);
        else               e = exp_idle(1'b1);
        step(st, k, d, adv, e, $sformatf("%s s%0d", tag, s));
        if (adv) break;
      end
    end
    chk({tag, " last"}, {16'h0, last_seen}, {16'h0, v.last_key});
    ks.key_advance_din  = 1'b0;
    ks.start_strobe_din = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    exp_t e;
    vecs[0] = '{KEY,   1'b0, 1'b0, 1'b0, 48'h1B02EFFC7072, 4'd1,  48'hCB3D8B0E17F5};
    vecs[1] = '{KEY,   1'b1, 1'b0, 1'b0, 48'hCB3D8B0E17F5, 4'd0,  48'h1B02EFFC7072};
    vecs[2] = '{KEY_P, 1'b0, 1'b0, 1'b0, 48'h1B02EFFC7072, 4'd1,  48'hCB3D8B0E17F5};
    vecs[3] = '{KEY_P, 1'b1, 1'b0, 1'b0, 48'hCB3D8B0E17F5, 4'd0,  48'h1B02EFFC7072};
    vecs[4] = '{KEY,   1'b0, 1'b1, 1'b0, 48'h1B02EFFC7072, 4'd1,  48'hCB3D8B0E17F5};
    vecs[5] = '{KEY,   1'b1, 1'b1, 1'b0, 48'hCB3D8B0E17F5, 4'd0,  48'h1B02EFFC7072};
    vecs[6] = '{KEY,   1'b0, 1'b0, 1'b1, 48'h1B02EFFC7072, 4'd1,  48'hCB3D8B0E17F5};

    reset = 1'b1;
    ks.start_strobe_din = 1'b0;
    ks.decrypt_mode_din = 1'b0;
    ks.key_din          = '0;
    ks.key_advance_din  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(exp_idle(1'b0));
    check_out("reset");
    reset = 1'b0;

    step(1'b0, KEY, 1'b0, 1'b1, exp_idle(1'b0), "idle_adv");

    // Back-to-back: each new start lands in the previous done cycle.
    for (int i = 0; i < 7; i++) begin
      run_schedule(vecs[i], $sformatf("vec%0d", i));
    end
    step(1'b0, KEY, 1'b0, 1'b0, exp_idle(1'b0), "post_done");

    // Abort at round 7 by asynchronous reset.
    step(1'b1, KEY, 1'b0, 1'b0, exp_round(1), "abort start");
    for (int s = 1; s < 7; s++) begin
      step(1'b0, KEY, 1'b0, 1'b1, exp_round(s + 1), $sformatf("abort s%0d", s));
    end
    ks.key_advance_din = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    sb_q.push_back(exp_idle(1'b0));
    check_out("abort async");
    @(posedge clk);
    #1;
    sb_q.push_back(exp_idle(1'b0));
    check_out("abort held");
    reset = 1'b0;
    step(1'b0, KEY, 1'b0, 1'b1, exp_idle(1'b0), "abort after");
    run_schedule(vecs[0], "post_abort");
    step(1'b0, KEY, 1'b0, 1'b0, exp_idle(1'b0), "final_idle");

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
